// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter and instruction fetch sequencer feeding the decoder
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      imem_rdata,
    input  logic             branch,
    input  logic             jump,
    input  logic             jumpaddr_src,
    input  logic             branch_cond,
    input  logic [31:0]      rs_data,
    input  logic             stall,
    input  logic             resume,
    output logic [31:0]      imem_addr,
    output logic [31:0]      pc_plus4,
    output logic [31:0]      inst,
    output logic             inst_valid,
    output logic             halted,
    output logic [CNT_W-1:0] retired_cnt
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        is_run;
    logic        syscall;
    logic [31:0] br_offset;
    logic [31:0] next_pc;

    assign imem_addr = pc;

    always_comb begin
        pc_plus4   = pc + 32'd4;
        is_run     = (state == RUN);
        inst_valid = is_run;
        inst       = is_run ? imem_rdata : 32'd0;
        syscall    = (imem_rdata[31:26] == 6'b000000) && (imem_rdata[5:0] == 6'b001100);
        br_offset  = {{14{imem_rdata[15]}}, imem_rdata[15:0], 2'b00};

        // jump outranks branch so a malformed decode still picks a single target
        next_pc = pc_plus4;
        if (syscall)
            next_pc = pc_plus4;
        else if (jump && jumpaddr_src)
            next_pc = rs_data & ~32'd3;
        else if (jump)
            next_pc = {pc_plus4[31:28], imem_rdata[25:0], 2'b00};
        else if (branch && branch_cond)
            next_pc = pc_plus4 + br_offset;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            halted      <= 1'b0;
            retired_cnt <= '0;
        end else begin
            case (state)
                BOOT: begin
                    state <= RUN;
                end
                RUN: begin
                    // a stalled syscall is simply re-examined on the next unstalled cycle
                    if (!stall) begin
                        pc          <= next_pc;
                        retired_cnt <= retired_cnt + CNT_W'(1);
                        if (syscall) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    if (resume) begin
                        state  <= RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state  <= BOOT;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed and randomized checks of pc_fetch_unit against a reference model
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] imem_rdata;
    logic        branch;
    logic        jump;
    logic        jumpaddr_src;
    logic        branch_cond;
    logic [31:0] rs_data;
    logic        stall;
    logic        resume;
    logic [31:0] imem_addr;
    logic [31:0] pc_plus4;
    logic [31:0] inst;
    logic        inst_valid;
    logic        halted;
    logic [31:0] retired_cnt;

    int checks = 0;
    int errors = 0;

    // reference model: mode 0 = boot, 1 = running, 2 = halted
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_rdata   (imem_rdata),
        .branch       (branch),
        .jump         (jump),
        .jumpaddr_src (jumpaddr_src),
        .branch_cond  (branch_cond),
        .rs_data      (rs_data),
        .stall        (stall),
        .resume       (resume),
        .imem_addr    (imem_addr),
        .pc_plus4     (pc_plus4),
        .inst         (inst),
        .inst_valid   (inst_valid),
        .halted       (halted),
        .retired_cnt  (retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [31:0] rd, input logic br, input logic jp, input logic js,
                          input logic bc, input logic [31:0] rs, input logic st, input logic rsm);
        imem_rdata   = rd;
        branch       = br;
        jump         = jp;
        jumpaddr_src = js;
        branch_cond  = bc;
        rs_data      = rs;
        stall        = st;
        resume       = rsm;
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_pc   = 32'h0;
        m_cnt  = 32'h0;
    endtask

    task automatic check_outputs(input string where);
        chk({where, ".pc"},       imem_addr,            m_pc);
        chk({where, ".pc_plus4"}, pc_plus4,             m_pc + 32'd4);
        chk({where, ".valid"},    32'(inst_valid),      32'(m_mode == 1));
        chk({where, ".inst"},     inst,                 (m_mode == 1) ? imem_rdata : 32'd0);
        chk({where, ".halted"},   32'(halted),          32'(m_mode == 2));
        chk({where, ".retired"},  retired_cnt,          m_cnt);
    endtask

    // checks the current cycle, advances the model, then crosses one rising edge
    task automatic step(input string where);
        logic        sys;
        int          off;
        #1;
        check_outputs(where);
        sys = (imem_rdata[31:26] == 6'd0) && (imem_rdata[5:0] == 6'd12);
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 2) begin
            if (resume) m_mode = 1;
        end else if (!stall) begin
            m_cnt = m_cnt + 1;
            if (sys) begin
                m_pc   = m_pc + 4;
                m_mode = 2;
            end else if (jump && jumpaddr_src) begin
                m_pc = (rs_data / 4) * 4;
            end else if (jump) begin
                m_pc = ((m_pc + 4) & 32'hF000_0000) + (32'(imem_rdata[25:0]) * 4);
            end else if (branch && branch_cond) begin
                off  = int'($signed(imem_rdata[15:0])) * 4;
                m_pc = m_pc + 4 + 32'(off);
            end else begin
                m_pc = m_pc + 4;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic jr_to(input logic [31:0] target);
        set_in(32'h0, 1'b0, 1'b1, 1'b1, 1'b0, target, 1'b0, 1'b0);
        step("jr_setup");
    endtask

    initial begin
        logic [31:0] rd;
        rst = 1'b1;
        set_in(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        model_reset();
        #1;
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // boot cycle then three NOP fetches
        for (int i = 0; i < 4; i++) step("nop");
        chk("nop_retired", retired_cnt, 32'd3);
        chk("nop_pc", imem_addr, 32'h0000_000C);

        jr_to(32'h10);
        set_in(32'h1400_FFFC, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
        step("bne_taken");
        chk("bne_taken_target", imem_addr, 32'h0000_0004);
        jr_to(32'h10);
        set_in(32'h1400_FFFC, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step("bne_not_taken");
        chk("bne_not_taken_target", imem_addr, 32'h0000_0014);

        jr_to(32'h4000_0020);
        set_in({6'h02, 26'h000_0100}, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step("j");
        chk("j_target", imem_addr, 32'h4000_0400);
        set_in(32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0123, 1'b0, 1'b0);
        step("jr");
        chk("jr_target", imem_addr, 32'h0000_0120);

        // jump beats branch when both are raised
        set_in({6'h02, 26'h000_0040}, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
        step("jump_over_branch");
        chk("jump_over_branch_target", imem_addr, 32'h0000_0100);

        jr_to(32'hFFFF_FFFC);
        set_in(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step("wrap");
        chk("wrap_target", imem_addr, 32'h0000_0000);

        jr_to(32'h30);
        set_in(32'h0000_000C, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        rd = retired_cnt;
        step("syscall");
        chk("syscall_halted", 32'(halted), 32'd1);
        chk("syscall_pc", imem_addr, 32'h0000_0034);
        chk("syscall_retired", retired_cnt, rd + 32'd1);
        for (int i = 0; i < 5; i++) begin
            set_in($urandom, 1'b0, 1'b0, 1'b0, 1'b0, $urandom, 1'(i & 1), 1'b0);
            step("halt_idle");
        end
        set_in(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        step("resume");
        chk("resume_pc", imem_addr, 32'h0000_0034);
        chk("resume_valid", 32'(inst_valid), 32'd1);

        jr_to(32'h08);
        for (int i = 0; i < 3; i++) begin
            set_in(32'h0000_000C, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
            step("stall_syscall");
        end
        chk("stall_pc", imem_addr, 32'h0000_0008);
        chk("stall_halted", 32'(halted), 32'd0);
        set_in(32'h0000_000C, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step("stall_release");
        chk("stall_release_halted", 32'(halted), 32'd1);
        set_in(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step("resume2");

        jr_to(32'h50);
        set_in(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("pre_reset_pc", imem_addr, 32'h0000_0050);
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("async_reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 400; i++) begin
            rd = $urandom;
            if ($urandom_range(0, 7) == 0) rd = {6'd0, rd[25:6], 6'd12};
            set_in(rd,
                   1'($urandom_range(0, 2) == 0),
                   1'($urandom_range(0, 3) == 0),
                   1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)),
                   $urandom,
                   1'($urandom_range(0, 4) == 0),
                   1'($urandom_range(0, 2) == 0));
            step("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and instruction-fetch sequencer directly upstream of the main decoder.
- Holds the PC, presents it to instruction memory, and forwards the fetched word to the decoder.
- Computes next-PC from the decoder's Branch, Jump and JumpaddrSrc outputs plus the ALU branch condition.
- Halts on syscall and counts retired instructions.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
CNT_W, 32, width of retired-instruction counter.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous active-high reset.
imem_rdata  input  32  instruction word read combinationally at imem_addr.
branch  input  1  decoder Branch.
jump  input  1  decoder Jump.
jumpaddr_src  input  1  decoder JumpaddrSrc; 1 = jr (target from rs_data), 0 = j (target from instruction field).
branch_cond  input  1  ALU result: branch condition true (bne: operands unequal; bgtz: rs > 0).
rs_data  input  32  register-file rs read value, used as the jr target.
stall  input  1  freeze PC and counter this cycle.
resume  input  1  leave HALT.
imem_addr  output  32  current PC.
pc_plus4  output  32  PC + 4.
inst  output  32  instruction to the decoder; 0 when inst_valid = 0.
inst_valid  output  1  inst is a live instruction this cycle.
halted  output  1  unit is in HALT.
retired_cnt  output  CNT_W  number of retired instructions.

Behaviour:
- Reset (async, rst = 1):
  - PC = RESET_PC.
  - State = BOOT.
  - retired_cnt = 0, halted = 0, inst_valid = 0, inst = 0.
- States and transitions:
  - BOOT: one cycle, no fetch, PC held. Next state RUN.
  - RUN: inst_valid = 1 and inst = imem_rdata, both combinational.
  - HALT: inst_valid = 0, PC held, halted = 1. resume = 1 → RUN at the next edge; first fetch is at the held PC.
- Syscall detection: imem_rdata[31:26] = 6'b000000 and imem_rdata[5:0] = 6'b001100, in RUN with stall = 0.
- Next-PC priority in RUN with stall = 0, evaluated top to bottom:
  1. syscall → PC = pc_plus4, state = HALT.
  2. jump & jumpaddr_src → PC = {rs_data[31:2], 2'b00}; low bits are forced to 0 and no fault is raised.
  3. jump & !jumpaddr_src → PC = {pc_plus4[31:28], imem_rdata[25:0], 2'b00}.
  4. branch & branch_cond → PC = pc_plus4 + {{14{imm[15]}}, imm[15:0], 2'b00}, where imm = imemrdata[15:0].
  5. otherwise → PC = pc_plus4.
- Arithmetic: all PC arithmetic is modulo 2^32, and 32'hFFFF_FFFC + 4 wraps to 0.
- No delay slots: the target applies to the next fetch.
- Stall:
  - Holds PC, state and retired_cnt.
  - inst_valid stays 1 in RUN so the decoder sees the same word.
  - stall together with syscall: stall wins; syscall is re-evaluated next cycle.
- retired_cnt increments by 1 on each RUN cycle with stall = 0, syscall included. It wraps at 2^CNT_W with no saturation.
- stall and resume in HALT: resume wins, since stall only affects RUN.
- Reset mid-operation: async return to BOOT from any state; the in-flight instruction is discarded and not counted.
- branch and jump both asserted: jump wins. The decoder never emits this combination; the priority is defined for robustness.
- All outputs other than inst, inst_valid and pc_plus4 are registered or derived from registered state only. pc_plus4 = PC + 4, combinational from the registered PC.

Test Plan:
- Reset then 4 cycles of NOPs (imem_rdata = 0): cycle 1 BOOT, inst_valid = 0, PC = 0. Then PC = 0, 4, 8; retired_cnt = 3; halted = 0.
- bne taken at PC = 0x10, imm = 16'hFFFC, branch = 1, branch_cond = 1: next PC = 0x14 − 16 = 0x04. Same with branch_cond = 0: next PC = 0x14.
- j at PC = 0x4000_0020 with target field 26'h0000100: next PC = 0x4000_0400. jr with rs_data = 0x0000_0123: next PC = 0x0000_0120.
- syscall at PC = 0x30: next edge halted = 1, PC = 0x34, inst_valid = 0, retired_cnt +1. 5 idle cycles: no change. Pulse resume: RUN, fetch at 0x34.
- stall held 3 cycles at PC = 0x08 carrying a syscall word: PC stays 0x08, retired_cnt constant, no halt. Release stall: HALT entered at the next edge.
- Assert rst mid-RUN at PC = 0x50 between clock edges: PC = RESET_PC, retired_cnt = 0 and inst_valid = 0 immediately, without waiting for a clock edge.
